// File: rtl/ring_frame_scheduler.sv
// ring_frame_scheduler
// Decides when the LED driver shifts a new frame and holds the frame contents
// steady in shadow registers while it does.
//
// A frame is owed ("pending") after reset, after an update_req pulse, whenever
// a requested field differs from what was last sent, and every PERIOD_CYCLES.
// Requests that land during a frame fold into a single follow-up frame.
//
// Ports
//   clk, res_n       clock (rising edge), async active-low reset
//   led_mask_in      [11:0] requested LED on-mask
//   colour_in        [2:0]  requested colour code
//   intensity_in     [7:0]  requested intensity
//   update_req       single-cycle frame request
//   driver_busy      high while the driver shifts a frame
//   refresh          one-cycle start pulse to the driver
//   led_mask_out, colour_out, intensity_out   shadow copy of the frame
//   frame_done       one-cycle pulse on the last latch-gap cycle
//   pending          a frame send is owed
//   timeout_err      sticky: driver never went busy after a refresh
module ring_frame_scheduler #(
  parameter int LATCH_CYCLES  = 3000,
  parameter int PERIOD_CYCLES = 500000,
  parameter int START_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [11:0] led_mask_in,
  input  logic [2:0]  colour_in,
  input  logic [7:0]  intensity_in,
  input  logic        update_req,
  input  logic        driver_busy,
  output logic        refresh,
  output logic [11:0] led_mask_out,
  output logic [2:0]  colour_out,
  output logic [7:0]  intensity_out,
  output logic        frame_done,
  output logic        pending,
  output logic        timeout_err
);

  typedef struct packed {
    logic [11:0] mask;
    logic [2:0]  colour;
    logic [7:0]  intensity;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_BUSY, S_LATCH
  } state_t;

  localparam logic [15:0] LATCH_LAST  = 16'(LATCH_CYCLES - 1);
  localparam logic [7:0]  TMO_LAST    = 8'(START_TIMEOUT - 1);
  localparam logic [19:0] PERIOD_LAST = 20'(PERIOD_CYCLES - 1);
  localparam bit          PERIOD_EN   = (PERIOD_CYCLES != 0);

  state_t      state, state_n;
  frame_t      frame_in, shadow;
  logic [15:0] latch_cnt;
  logic [7:0]  tmo_cnt;
  logic [19:0] period_cnt;
  logic        period_hit, timeout_hit, pend_set;

  assign frame_in = '{mask: led_mask_in, colour: colour_in, intensity: intensity_in};

  assign period_hit  = PERIOD_EN && (period_cnt == PERIOD_LAST);
  assign timeout_hit = (state == S_WAIT_BUSY) && !driver_busy && (tmo_cnt == TMO_LAST);
  // Field changes while LOAD is copying them are already in the frame.
  assign pend_set    = update_req || period_hit ||
                       ((frame_in != shadow) && (state != S_LOAD));

  always_comb begin
    state_n    = state;
    refresh    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE:      if (pending) state_n = S_LOAD;
      S_LOAD:      state_n = S_START;
      S_START: begin
        refresh = 1'b1;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (driver_busy)      state_n = S_BUSY;
        else if (timeout_hit) state_n = S_LATCH;
      end
      S_BUSY:      if (!driver_busy) state_n = S_LATCH;
      S_LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          frame_done = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= S_IDLE;
      shadow      <= '0;
      latch_cnt   <= '0;
      tmo_cnt     <= '0;
      period_cnt  <= '0;
      pending     <= 1'b1;   // first frame goes out right after reset
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;

      if (state == S_LOAD) shadow <= frame_in;

      latch_cnt <= (state == S_LATCH)     ? latch_cnt + 16'd1 : '0;
      tmo_cnt   <= (state == S_WAIT_BUSY) ? tmo_cnt + 8'd1    : '0;

      // Free-running in every state; only LOAD re-phases it.
      if (state == S_LOAD || period_hit) period_cnt <= '0;
      else                               period_cnt <= period_cnt + 20'd1;

      // A new request on the LOAD cycle must survive the clear.
      pending <= pend_set || (pending && (state != S_LOAD));

      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  assign led_mask_out  = shadow.mask;
  assign colour_out    = shadow.colour;
  assign intensity_out = shadow.intensity;

endmodule

// File: tb/tb_ring_frame_scheduler.sv
// Directed bench for ring_frame_scheduler. Inputs change and outputs are
// sampled on the falling edge. A second instance with PERIOD_CYCLES=1000 and
// its own reset checks the periodic re-send in isolation.
module tb_ring_frame_scheduler;

  localparam int LAT = 20;
  localparam int TMO = 8;
  localparam int PER = 1000;

  logic        clk = 1'b0;
  logic        res_n, res_n_p;
  logic [11:0] led_mask_in;
  logic [2:0]  colour_in;
  logic [7:0]  intensity_in;
  logic        update_req, busy;
  logic        refresh, frame_done, pending, timeout_err;
  logic [11:0] led_mask_out;
  logic [2:0]  colour_out;
  logic [7:0]  intensity_out;
  logic        p_refresh, p_frame_done, p_pending, p_timeout_err;
  logic [11:0] p_mask;
  logic [2:0]  p_colour;
  logic [7:0]  p_intensity;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ring_frame_scheduler #(.LATCH_CYCLES(LAT), .PERIOD_CYCLES(0), .START_TIMEOUT(TMO)) u_dut (
    .clk(clk), .res_n(res_n),
    .led_mask_in(led_mask_in), .colour_in(colour_in), .intensity_in(intensity_in),
    .update_req(update_req), .driver_busy(busy),
    .refresh(refresh), .led_mask_out(led_mask_out), .colour_out(colour_out),
    .intensity_out(intensity_out), .frame_done(frame_done), .pending(pending),
    .timeout_err(timeout_err));

  ring_frame_scheduler #(.LATCH_CYCLES(LAT), .PERIOD_CYCLES(PER), .START_TIMEOUT(TMO)) u_per (
    .clk(clk), .res_n(res_n_p),
    .led_mask_in(12'h000), .colour_in(3'd0), .intensity_in(8'h00),
    .update_req(1'b0), .driver_busy(1'b0),
    .refresh(p_refresh), .led_mask_out(p_mask), .colour_out(p_colour),
    .intensity_out(p_intensity), .frame_done(p_frame_done), .pending(p_pending),
    .timeout_err(p_timeout_err));

  // Falling edges until refresh is seen; n = -1 if the bound runs out.
  task automatic wait_refresh(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max && n < 0; i++) begin
      @(negedge clk);
      if (refresh) n = i;
    end
  endtask

  task automatic pulse_update();
    @(negedge clk); update_req = 1'b1;
    @(negedge clk); update_req = 1'b0;
  endtask

  // Called on the refresh cycle: plays the driver (busy for busy_cycles),
  // optionally changes the mask / pulses update_req meanwhile, then returns
  // on the frame_done cycle. gap = falling edges from busy drop to frame_done.
  task automatic drive_frame(input int busy_cycles, input int change_at,
                             input logic [11:0] new_mask, input int n_req,
                             output int gap, output int extra_ref,
                             output logic mask_moved);
    logic [11:0] m0;
    m0 = led_mask_out; gap = -1; extra_ref = 0; mask_moved = 1'b0;
    busy = 1'b1;
    for (int i = 1; i <= busy_cycles; i++) begin
      @(negedge clk);
      if (refresh) extra_ref++;
      if (led_mask_out !== m0) mask_moved = 1'b1;
      update_req = (i % 2 == 0) && (i / 2 <= n_req);
      if (i == change_at) led_mask_in = new_mask;
    end
    busy = 1'b0; update_req = 1'b0;
    for (int i = 1; i <= LAT + 10 && gap < 0; i++) begin
      @(negedge clk);
      if (refresh) extra_ref++;
      if (led_mask_out !== m0) mask_moved = 1'b1;
      if (frame_done) gap = i;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (refresh !== 1'b0) $display("FAIL rst_refresh got %b want 0", refresh); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b want 0", frame_done); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err got %b want 0", timeout_err); else passed++;
    total++; if (pending !== 1'b1) $display("FAIL rst_pending got %b want 1", pending); else passed++;
    total++; if ({led_mask_out, colour_out, intensity_out} !== 23'h0)
      $display("FAIL rst_shadow got %h want 0", {led_mask_out, colour_out, intensity_out}); else passed++;
    res_n = 1'b1;
  endtask

  task automatic test_basic();
    int n, gap, extra, cnt;
    logic moved;
    wait_refresh(10, n);
    total++; if (n !== 2) $display("FAIL basic_first_refresh got %0d want 2", n); else passed++;
    drive_frame(10, 0, 12'h0, 0, gap, extra, moved);
    total++; if (extra !== 0) $display("FAIL basic_single_refresh got %0d extra want 0", extra); else passed++;
    total++; if (gap !== LAT) $display("FAIL basic_latch_gap got %0d want %0d", gap, LAT); else passed++;
    @(negedge clk);
    total++; if (pending !== 1'b0) $display("FAIL basic_pending got %b want 0", pending); else passed++;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (refresh) cnt++; end
    total++; if (cnt !== 0) $display("FAIL basic_idle_refresh got %0d want 0", cnt); else passed++;
  endtask

  task automatic test_shadow();
    int n, gap, extra;
    logic moved;
    pulse_update();
    wait_refresh(10, n);
    total++; if (n !== 2) $display("FAIL shadow_refresh got %0d want 2", n); else passed++;
    drive_frame(10, 3, 12'h0F0, 0, gap, extra, moved);
    total++; if (moved !== 1'b0) $display("FAIL shadow_stable got moved=%b want 0", moved); else passed++;
    total++; if (pending !== 1'b1) $display("FAIL shadow_pending got %b want 1", pending); else passed++;
    // frame_done -> IDLE -> LOAD -> START
    wait_refresh(10, n);
    total++; if (n !== 3) $display("FAIL shadow_second_refresh got %0d want 3", n); else passed++;
    total++; if (led_mask_out !== 12'h0F0) $display("FAIL shadow_mask got %h want 0f0", led_mask_out); else passed++;
    drive_frame(10, 0, 12'h0, 0, gap, extra, moved);
    total++; if (gap !== LAT) $display("FAIL shadow_gap got %0d want %0d", gap, LAT); else passed++;
    @(negedge clk);
    total++; if (pending !== 1'b0) $display("FAIL shadow_pending_clr got %b want 0", pending); else passed++;
  endtask

  task automatic test_coalesce();
    int n, gap, extra, cnt;
    logic moved;
    @(negedge clk); colour_in = 3'd5; intensity_in = 8'hA5;
    wait_refresh(10, n);
    total++; if (n !== 3) $display("FAIL coal_change_refresh got %0d want 3", n); else passed++;
    total++; if ({colour_out, intensity_out} !== {3'd5, 8'hA5})
      $display("FAIL coal_fields got %h/%h want 5/a5", colour_out, intensity_out); else passed++;
    drive_frame(10, 0, 12'h0, 3, gap, extra, moved);
    total++; if (extra !== 0) $display("FAIL coal_in_frame_refresh got %0d want 0", extra); else passed++;
    total++; if (pending !== 1'b1) $display("FAIL coal_pending got %b want 1", pending); else passed++;
    wait_refresh(10, n);
    total++; if (n !== 3) $display("FAIL coal_followup got %0d want 3", n); else passed++;
    drive_frame(10, 0, 12'h0, 0, gap, extra, moved);
    cnt = extra;
    repeat (60) begin @(negedge clk); if (refresh) cnt++; end
    total++; if (cnt !== 0) $display("FAIL coal_one_extra got %0d more refreshes want 0", cnt); else passed++;
    total++; if (pending !== 1'b0) $display("FAIL coal_pending_clr got %b want 0", pending); else passed++;
  endtask

  task automatic test_timeout();
    int n, err_at, done_at;
    pulse_update();
    wait_refresh(10, n);
    total++; if (n !== 2) $display("FAIL tmo_refresh got %0d want 2", n); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL tmo_err_before got %b want 0", timeout_err); else passed++;
    err_at = -1; done_at = -1;
    for (int i = 1; i <= TMO + LAT + 10 && done_at < 0; i++) begin
      @(negedge clk);
      if (timeout_err && err_at < 0) err_at = i;
      if (frame_done) done_at = i;
    end
    // WAIT_BUSY spans TMO cycles after the refresh cycle; the flag shows on
    // the first LATCH cycle, frame_done on the last.
    total++; if (err_at !== TMO + 1) $display("FAIL tmo_err_time got %0d want %0d", err_at, TMO + 1); else passed++;
    total++; if (done_at !== TMO + LAT) $display("FAIL tmo_done_time got %0d want %0d", done_at, TMO + LAT); else passed++;
    repeat (5) @(negedge clk);
    total++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky got %b want 1", timeout_err); else passed++;
    total++; if (pending !== 1'b0) $display("FAIL tmo_pending got %b want 0", pending); else passed++;
  endtask

  task automatic test_mid_reset();
    int n, gap, extra, fd;
    logic moved;
    pulse_update();
    wait_refresh(10, n);
    busy = 1'b1;
    repeat (5) @(negedge clk);
    res_n = 1'b0;
    #1;
    total++; if (refresh !== 1'b0) $display("FAIL mrst_refresh got %b want 0", refresh); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL mrst_frame_done got %b want 0", frame_done); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL mrst_err got %b want 0", timeout_err); else passed++;
    total++; if (pending !== 1'b1) $display("FAIL mrst_pending got %b want 1", pending); else passed++;
    total++; if ({led_mask_out, colour_out, intensity_out} !== 23'h0)
      $display("FAIL mrst_shadow got %h want 0", {led_mask_out, colour_out, intensity_out}); else passed++;
    fd = 0;
    repeat (2) begin @(negedge clk); if (frame_done) fd++; end
    busy = 1'b0; res_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 10 && n < 0; i++) begin
      @(negedge clk);
      if (frame_done) fd++;
      if (refresh) n = i;
    end
    total++; if (fd !== 0) $display("FAIL mrst_no_done got %0d pulses want 0", fd); else passed++;
    total++; if (n !== 2) $display("FAIL mrst_restart got %0d want 2", n); else passed++;
    total++; if (led_mask_out !== 12'h0F0) $display("FAIL mrst_reload got %h want 0f0", led_mask_out); else passed++;
    drive_frame(6, 0, 12'h0, 0, gap, extra, moved);
    total++; if (gap !== LAT) $display("FAIL mrst_gap got %0d want %0d", gap, LAT); else passed++;
  endtask

  task automatic test_period();
    int t[8];
    int cnt;
    cnt = 0;
    @(negedge clk); res_n_p = 1'b1;
    for (int i = 1; i <= 3200; i++) begin
      @(negedge clk);
      if (p_refresh) begin
        if (cnt < 8) t[cnt] = i;
        cnt++;
      end
    end
    // Period restarts in LOAD; the hit registers into pending and IDLE takes
    // one more cycle to reach LOAD, so START-to-START is PER+2 here (the
    // timeout frame is ~30 cycles, well under PER).
    total++; if (cnt !== 4) $display("FAIL per_count got %0d want 4", cnt); else passed++;
    total++; if (t[0] !== 2) $display("FAIL per_first got %0d want 2", t[0]); else passed++;
    for (int k = 1; k < 4 && k < cnt; k++) begin
      total++;
      if (t[k] - t[k-1] !== PER + 2)
        $display("FAIL per_spacing%0d got %0d want %0d", k, t[k] - t[k-1], PER + 2);
      else passed++;
    end
  endtask

  initial begin
    res_n = 1'b0; res_n_p = 1'b0;
    led_mask_in = '0; colour_in = '0; intensity_in = '0;
    update_req = 1'b0; busy = 1'b0;
    test_reset();
    test_basic();
    test_shadow();
    test_coalesce();
    test_timeout();
    test_mid_reset();
    test_period();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ring_frame_scheduler.md
RING_FRAME_SCHEDULER -- requirements
Module: ring_frame_scheduler

Interface
REQ-001 SHALL have parameter LATCH_CYCLES, default 3000, meaning the minimum idle gap after a frame, in clk cycles (60 us at 50 MHz); legal range 1..65535.
REQ-002 SHALL have parameter PERIOD_CYCLES, default 500000, meaning the periodic re-send interval in clk cycles; legal range 0..1048575, and 0 disables the periodic re-send.
REQ-003 SHALL have parameter START_TIMEOUT, default 255, meaning the maximum number of cycles to wait for driver_busy to rise after refresh; legal range 1..255.
REQ-004 SHALL have one clock, clk, and a reset, res_n, that is asynchronous and active-low:
- clk  input  1  system clock, rising edge.
- res_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have the following frame-request and driver-handshake ports:
- led_mask_in  input  12  requested LED on-mask.
- colour_in  input  3  requested colour code.
- intensity_in  input  8  requested intensity.
- update_req  input  1  single-cycle request for a frame send.
- driver_busy  input  1  high while the LED driver shifts a frame.
REQ-006 SHALL have the following outputs to the LED driver and status:
- refresh  output  1  one-cycle start pulse to the driver.
- led_mask_out  output  12  shadow mask, stable for the whole frame.
- colour_out  output  3  shadow colour.
- intensity_out  output  8  shadow intensity.
- frame_done  output  1  one-cycle pulse at the end of the latch gap.
- pending  output  1  a frame send is owed.
- timeout_err  output  1  sticky flag: the driver never went busy.

Function
REQ-007 SHALL implement the states IDLE, LOAD, START, WAIT_BUSY, BUSY and LATCH, with one state change at most per clock.
REQ-008 SHALL move from IDLE to LOAD on the cycle after pending is seen high; if pending is low it SHALL stay in IDLE.
REQ-009 SHALL, in LOAD, copy the three *_in buses into the shadow registers, clear pending, restart the period counter, and go to START.
REQ-010 SHALL assert refresh for exactly one cycle while in START, then go to WAIT_BUSY.
REQ-011 SHALL, in WAIT_BUSY, go to BUSY when driver_busy=1; after START_TIMEOUT cycles with driver_busy=0 it SHALL set timeout_err and go to LATCH.
REQ-012 SHALL stay in BUSY while driver_busy=1 and go to LATCH on the first cycle with driver_busy=0.
REQ-013 SHALL stay in LATCH for exactly LATCH_CYCLES cycles, pulse frame_done on the last LATCH cycle, then return to IDLE.
REQ-014 SHALL set pending (sticky) on update_req=1 in any state.
REQ-015 SHALL set pending (sticky) on any cycle where any *_in differs from its shadow register, in any state except LOAD.
REQ-016 SHALL set pending (sticky) when the 20-bit period counter reaches PERIOD_CYCLES-1 with PERIOD_CYCLES≠0; the counter SHALL then wrap to 0.
REQ-017 SHALL count the period counter in every state and restart it only in LOAD or on reset.
REQ-018 SHALL resolve a pending set and the LOAD clear on the same cycle with the set winning, so pending stays 1.
REQ-019 SHALL change the shadow registers only in LOAD, never during START, WAIT_BUSY, BUSY or LATCH.
REQ-020 SHALL serve requests arriving during a frame with exactly one further frame, sent after LATCH ends; multiple requests SHALL coalesce into that one frame.
REQ-021 SHALL ignore driver_busy outside WAIT_BUSY and BUSY.
REQ-022 SHALL clear timeout_err only on reset.
REQ-023 SHALL use a 16-bit latch counter and an 8-bit timeout counter.

Reset
REQ-024 SHALL, while res_n=0, set state to IDLE, all counters to 0, shadow registers to 0, refresh=0, frame_done=0 and timeout_err=0.
REQ-025 SHALL set pending=1 on reset, so the first frame sends immediately after reset release.
REQ-026 SHALL, on reset in mid-frame, abort the current frame at once, with no frame_done pulse.

Verification
REQ-027 SHALL cover: release reset with inputs 0 and driver_busy held high for 10 cycles after refresh -> refresh pulses once, frame_done fires LATCH_CYCLES cycles after busy falls, then pending=0 and refresh stays idle.
REQ-028 SHALL cover: change led_mask_in to 12'h0F0 while in BUSY -> led_mask_out does not change during the frame; after LATCH, a second refresh fires and led_mask_out=12'h0F0.
REQ-029 SHALL cover: three update_req pulses while in BUSY -> exactly one additional refresh after LATCH.
REQ-030 SHALL cover: driver_busy tied to 0 -> timeout_err=1 START_TIMEOUT cycles after refresh, then the LATCH gap and frame_done still occur.
REQ-031 SHALL cover: PERIOD_CYCLES=1000 with static inputs -> refresh pulses repeat with spacing equal to max(1000, frame length).
REQ-032 SHALL cover: res_n asserted in the middle of BUSY -> all outputs reset immediately, no frame_done, and a new frame starts after release.
